// File: rtl/d_branch_cmp_pkg.sv
// Shared definitions for the D-stage branch resolution unit.
// Holds the branch condition encodings, the 2-bit predictor counter states
// and the counter step function used by the history table.
package d_branch_cmp_pkg;

   // Branch condition select. The two top codes never report taken.
   typedef enum logic [2:0] {
      CMP_EQ   = 3'b000,
      CMP_NE   = 3'b001,
      CMP_LEZ  = 3'b010,
      CMP_GTZ  = 3'b011,
      CMP_LTZ  = 3'b100,
      CMP_GEZ  = 3'b101,
      CMP_RSV6 = 3'b110,
      CMP_RSV7 = 3'b111
   } cmp_mode_e;

   // 2-bit saturating predictor counter; bit 1 is the prediction.
   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t SNT = 2'b00;  // strongly not taken
   localparam bht_ctr_t WNT = 2'b01;  // weakly not taken
   localparam bht_ctr_t WT  = 2'b10;  // weakly taken
   localparam bht_ctr_t ST  = 2'b11;  // strongly taken

   // Entries start weakly not taken so one taken outcome flips them.
   localparam bht_ctr_t BHT_RESET = WNT;

   // One saturating step toward ST on taken, toward SNT otherwise.
   function automatic bht_ctr_t bht_next(input bht_ctr_t cur, input logic taken);
      bht_ctr_t nxt;
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         default: nxt = taken ? ST  : WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/d_branch_cmp_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters indexed by PC.
// Latency: prediction is combinational from i_rd_pc; updates land on the next clk edge.
// Backpressure: none; the caller qualifies i_upd_en with stall/flush.
//
// Ports:
//   clk, reset   clock and asynchronous active-low reset (entries -> BHT_RESET)
//   i_rd_pc      PC whose entry drives o_pred
//   i_wr_pc      PC whose entry is stepped when i_upd_en is high
//   i_upd_en     apply one saturating step this edge
//   i_taken      step direction (1 toward ST, 0 toward SNT)
//   o_pred       bit 1 of the entry selected by i_rd_pc
module d_bht
   import d_branch_cmp_pkg::*;
#(
   parameter int BHT_DEPTH = 16,
   parameter int PC_LSB    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_rd_pc,
   input  logic [31:0] i_wr_pc,
   input  logic        i_upd_en,
   input  logic        i_taken,
   output logic        o_pred
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0] w_rd_idx;
   logic [IDX_W-1:0] w_wr_idx;
   bht_ctr_t         r_tbl [BHT_DEPTH];

   // Index is the IDX_W bits starting at PC_LSB; higher PC bits alias.
   assign w_rd_idx = IDX_W'(i_rd_pc >> PC_LSB);
   assign w_wr_idx = IDX_W'(i_wr_pc >> PC_LSB);

   // Reads see the stored value, so a same-cycle update of the same
   // entry is reported with its pre-update state.
   assign o_pred = r_tbl[w_rd_idx][1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            r_tbl[i] <= BHT_RESET;
         end
      end else if (i_upd_en) begin
         r_tbl[w_wr_idx] <= bht_next(r_tbl[w_wr_idx], i_taken);
      end
   end

endmodule

// File: rtl/d_branch_cmp.sv
// D-stage branch resolution: condition compare, BHT prediction, mispredict pulse, event counters.
// Latency: D_CMP_out/pred_taken combinational; mispredict and counters registered, one cycle.
// Backpressure: stall or flush suppress the resolve event (no update, count or pulse).
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   rs_Data, rt_Data    forwarded operands (rt only used by EQ/NE)
//   cmp_mode            branch condition select (cmp_mode_e)
//   br_valid            D-stage instruction is a branch
//   D_PC                PC of the D-stage instruction (table index source)
//   stall, flush        D-stage hold / squash; either blocks resolution
//   D_CMP_out           raw condition result, not gated by br_valid
//   pred_taken          prediction from the table entry for D_PC
//   mispredict          one-cycle pulse after a resolve that disagreed with its prediction
//   br_cnt, taken_cnt   resolved / resolved-taken branch counts, wrapping
module d_branch_cmp
   import d_branch_cmp_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int BHT_DEPTH = 16,
   parameter int PC_LSB    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rs_Data,
   input  logic [WIDTH-1:0] rt_Data,
   input  logic [2:0]       cmp_mode,
   input  logic             br_valid,
   input  logic [31:0]      D_PC,
   input  logic             stall,
   input  logic             flush,
   output logic             D_CMP_out,
   output logic             pred_taken,
   output logic             mispredict,
   output logic [31:0]      br_cnt,
   output logic [31:0]      taken_cnt
);

   logic        w_rs_neg;
   logic        w_rs_zero;
   logic        w_eq;
   logic        w_taken;
   logic        w_pred;
   logic        w_resolve;
   logic        r_mispredict;
   logic [31:0] r_br_cnt;
   logic [31:0] r_taken_cnt;

   // Signed tests against zero reduce to the sign bit and a zero detect.
   assign w_rs_neg  = rs_Data[WIDTH-1];
   assign w_rs_zero = (rs_Data == '0);
   assign w_eq      = (rs_Data == rt_Data);

   always_comb begin
      w_taken = 1'b0;
      case (cmp_mode_e'(cmp_mode))
         CMP_EQ:  w_taken = w_eq;
         CMP_NE:  w_taken = !w_eq;
         CMP_LEZ: w_taken = w_rs_neg || w_rs_zero;
         CMP_GTZ: w_taken = !w_rs_neg && !w_rs_zero;
         CMP_LTZ: w_taken = w_rs_neg;
         CMP_GEZ: w_taken = !w_rs_neg;
         default: w_taken = 1'b0;
      endcase
   end

   // Both stall and flush override br_valid.
   assign w_resolve = br_valid && !stall && !flush;

   d_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .PC_LSB    (PC_LSB)
   ) u_bht (
      .clk      (clk),
      .reset    (reset),
      .i_rd_pc  (D_PC),
      .i_wr_pc  (D_PC),
      .i_upd_en (w_resolve),
      .i_taken  (w_taken),
      .o_pred   (w_pred)
   );

   // Mispredict is rewritten every cycle, so it self-clears after one cycle
   // and consecutive resolves produce independent pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mispredict <= 1'b0;
         r_br_cnt     <= '0;
         r_taken_cnt  <= '0;
      end else begin
         r_mispredict <= w_resolve && (w_pred != w_taken);
         if (w_resolve) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_taken) begin
               r_taken_cnt <= r_taken_cnt + 32'd1;
            end
         end
      end
   end

   assign D_CMP_out  = w_taken;
   assign pred_taken = w_pred;
   assign mispredict = r_mispredict;
   assign br_cnt     = r_br_cnt;
   assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_d_branch_cmp.sv
// Bench for d_branch_cmp: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the branch unit.
module tb_d_branch_cmp;

   logic        clk;
   logic        reset;
   logic [31:0] rs_Data;
   logic [31:0] rt_Data;
   logic [2:0]  cmp_mode;
   logic        br_valid;
   logic [31:0] D_PC;
   logic        stall;
   logic        flush;
   logic        D_CMP_out;
   logic        pred_taken;
   logic        mispredict;
   logic [31:0] br_cnt;
   logic [31:0] taken_cnt;

   int n_checks;
   int n_fail;
   bit chk_en;

   d_branch_cmp #(
      .WIDTH     (32),
      .BHT_DEPTH (16),
      .PC_LSB    (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_Data    (rs_Data),
      .rt_Data    (rt_Data),
      .cmp_mode   (cmp_mode),
      .br_valid   (br_valid),
      .D_PC       (D_PC),
      .stall      (stall),
      .flush      (flush),
      .D_CMP_out  (D_CMP_out),
      .pred_taken (pred_taken),
      .mispredict (mispredict),
      .br_cnt     (br_cnt),
      .taken_cnt  (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic exp_taken(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
      case (m)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return $signed(a) <= 0;
         3'd3:    return $signed(a) > 0;
         3'd4:    return $signed(a) < 0;
         3'd5:    return $signed(a) >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   int          m_tbl [16];
   logic [31:0] m_br;
   logic [31:0] m_tk;
   logic        m_mp;

   always @(posedge clk or negedge reset) begin
      bit res;
      bit tk;
      int ix;
      int cur;
      if (!reset) begin
         for (int i = 0; i < 16; i++) m_tbl[i] <= 1;
         m_br <= 0;
         m_tk <= 0;
         m_mp <= 0;
      end else begin
         res = br_valid && !stall && !flush;
         tk  = exp_taken(cmp_mode, rs_Data, rt_Data);
         ix  = m_idx(D_PC);
         cur = m_tbl[ix];
         m_mp <= res && ((cur >= 2) != tk);
         if (res) begin
            m_br <= m_br + 1;
            if (tk) m_tk <= m_tk + 1;
            m_tbl[ix] <= tk ? ((cur < 3) ? cur + 1 : 3) : ((cur > 0) ? cur - 1 : 0);
         end
      end
   end

   // Per-cycle compare, sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_d_cmp_out", {31'd0, D_CMP_out}, {31'd0, exp_taken(cmp_mode, rs_Data, rt_Data)});
         check("model_pred_taken", {31'd0, pred_taken}, {31'd0, m_tbl[m_idx(D_PC)] >= 2});
         check("model_mispredict", {31'd0, mispredict}, {31'd0, m_mp});
         check("model_br_cnt", br_cnt, m_br);
         check("model_taken_cnt", taken_cnt, m_tk);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic sweep_ones [8];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      chk_en   = 0;
      reset    = 1'b1;
      rs_Data  = 32'd0;
      rt_Data  = 32'd0;
      cmp_mode = 3'd0;
      br_valid = 1'b0;
      D_PC     = 32'h3000;
      stall    = 1'b0;
      flush    = 1'b0;
      sweep_ones = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      #2 reset = 1'b0;
      #1 chk_en = 1;
      #9 reset = 1'b1;  // released between edges
      #1;
      check("reset_pred", {31'd0, pred_taken}, 32'd0);
      check("reset_mispredict", {31'd0, mispredict}, 32'd0);
      check("reset_br_cnt", br_cnt, 32'd0);
      check("reset_taken_cnt", taken_cnt, 32'd0);

      // Mode sweep with all-ones operands, then rs = 0.
      rs_Data = 32'hFFFF_FFFF;
      rt_Data = 32'hFFFF_FFFF;
      for (int m = 0; m < 8; m++) begin
         cmp_mode = 3'(m);
         #1 check($sformatf("sweep_ones_mode%0d", m), {31'd0, D_CMP_out}, {31'd0, sweep_ones[m]});
         tick();
      end
      rs_Data = 32'd0;
      cmp_mode = 3'd2; #1 check("zero_lez", {31'd0, D_CMP_out}, 32'd1);
      cmp_mode = 3'd5; #1 check("zero_gez", {31'd0, D_CMP_out}, 32'd1);
      cmp_mode = 3'd3; #1 check("zero_gtz", {31'd0, D_CMP_out}, 32'd0);
      tick();

      // Four taken EQ branches at 0x3004: WNT -> WT -> ST -> ST -> ST.
      D_PC = 32'h3004; cmp_mode = 3'd0;
      rs_Data = 32'h1234; rt_Data = 32'h1234;
      br_valid = 1'b1;
      #1 check("taken_pred0", {31'd0, pred_taken}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("taken_mp%0d", k), {31'd0, mispredict}, (k == 0) ? 32'd1 : 32'd0);
         check($sformatf("taken_pred%0d", k + 1), {31'd0, pred_taken}, 32'd1);
      end
      check("taken_br_cnt", br_cnt, 32'd4);
      check("taken_taken_cnt", taken_cnt, 32'd4);
      // Saturated at ST: one not-taken leaves it predicting taken.
      rt_Data = 32'h0;
      tick();
      check("sat_mp", {31'd0, mispredict}, 32'd1);
      check("sat_pred", {31'd0, pred_taken}, 32'd1);
      check("sat_br_cnt", br_cnt, 32'd5);
      check("sat_taken_cnt", taken_cnt, 32'd4);
      br_valid = 1'b0;
      tick();
      check("sat_mp_clear", {31'd0, mispredict}, 32'd0);

      // Async reset between edges, then stalled branch at 0x3008.
      reset = 1'b0;
      #1 check("areset_br_cnt", br_cnt, 32'd0);
      check("areset_pred_3004", {31'd0, pred_taken}, 32'd0);
      reset = 1'b1;
      tick();
      D_PC = 32'h3008; rt_Data = 32'h1234; br_valid = 1'b1; stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall_br_cnt%0d", k), br_cnt, 32'd0);
         check($sformatf("stall_mp%0d", k), {31'd0, mispredict}, 32'd0);
      end
      stall = 1'b0;
      tick();
      check("release_mp", {31'd0, mispredict}, 32'd1);
      check("release_br_cnt", br_cnt, 32'd1);
      br_valid = 1'b0;
      tick();
      check("release_mp_clear", {31'd0, mispredict}, 32'd0);

      // flush+stall, then flush alone, with a not-taken outcome.
      br_valid = 1'b1; stall = 1'b1; flush = 1'b1; rt_Data = 32'h0;
      tick(); tick();
      check("fs_br_cnt", br_cnt, 32'd1);
      check("fs_mp", {31'd0, mispredict}, 32'd0);
      check("fs_pred", {31'd0, pred_taken}, 32'd1);
      stall = 1'b0;
      tick();
      check("flush_br_cnt", br_cnt, 32'd1);
      check("flush_pred", {31'd0, pred_taken}, 32'd1);
      br_valid = 1'b0; flush = 1'b0;
      tick();

      // Aliasing: 0x3040 and 0x3000 share index 0.
      D_PC = 32'h3040; rt_Data = 32'h1234; br_valid = 1'b1;
      #1 check("alias_pred_before", {31'd0, pred_taken}, 32'd0);
      tick();
      br_valid = 1'b0; D_PC = 32'h3000;
      #1 check("alias_pred_after", {31'd0, pred_taken}, 32'd1);
      // Reset mid-cycle with a pending resolve; the edge inside reset is discarded.
      br_valid = 1'b1;
      #1 reset = 1'b0;
      #1 check("alias_reset_pred", {31'd0, pred_taken}, 32'd0);
      check("alias_reset_br_cnt", br_cnt, 32'd0);
      check("alias_reset_taken_cnt", taken_cnt, 32'd0);
      check("alias_reset_mp", {31'd0, mispredict}, 32'd0);
      tick();
      check("alias_hold_br_cnt", br_cnt, 32'd0);
      check("alias_hold_pred", {31'd0, pred_taken}, 32'd0);
      br_valid = 1'b0;
      reset = 1'b1;
      tick(); tick();
      check("final_br_cnt", br_cnt, 32'd0);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
